// File: rtl/retire_stage.sv
// ---------------------------------------------------------------------------
// retire_stage
//
// Retires up to N in-order instructions per cycle from the ROB commit packet.
// It keeps the committed (architectural) register map, hands superseded
// physical registers back to the free list, counts retirements and stops the
// machine on halt or illegal.
//
// Commit packet layout: N entries of ENTRY_WIDTH bits, slot 0 (oldest) in the
// least significant entry. Within one entry, from LSB upwards:
//   [PRN_WIDTH-1:0]        dest_prn   new physical register for dest_arn
//   [ARN_WIDTH-1:0]        dest_arn   architectural destination (0 = none)
//   [31:0]                 pc
//   [0]                    illegal
//   [0]                    halt
//   [0]                    success    0 = mispredicted branch
//   [0]                    executed   entry has completed
//
// Ports
//   clock          in   1                    clock
//   reset          in   1                    synchronous, active-high
//   rob_ct_packet  in   N*ENTRY_WIDTH        commit entries, slot 0 oldest
//   squash         in   1                    ROB flush, same cycle as packet
//   retire_valid   out  N                    slot i retired last cycle
//   retire_pc      out  N*32                 PC of each retired slot
//   free_valid     out  N                    free_prn[i] returns to free list
//   free_prn       out  N*PRN_WIDTH          superseded physical registers
//   arch_map       out  ARCH_REGS*PRN_WIDTH  committed arch -> PRN map
//   recover_valid  out  1                    pulse: arch_map usable for recovery
//   halted         out  1                    machine stopped (sticky)
//   illegal        out  1                    stopped on illegal (sticky)
//   retire_count   out  64                   total retired instructions
// ---------------------------------------------------------------------------
module retire_stage #(
    parameter int N           = 2,
    parameter int PRN_WIDTH   = 6,
    parameter int ARCH_REGS   = 32,
    localparam int ARN_WIDTH   = $clog2(ARCH_REGS),
    localparam int ENTRY_WIDTH = PRN_WIDTH + ARN_WIDTH + 36
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N*ENTRY_WIDTH-1:0]       rob_ct_packet,
    input  logic                           squash,
    output logic [N-1:0]                   retire_valid,
    output logic [N*32-1:0]                retire_pc,
    output logic [N-1:0]                   free_valid,
    output logic [N*PRN_WIDTH-1:0]         free_prn,
    output logic [ARCH_REGS*PRN_WIDTH-1:0] arch_map,
    output logic                           recover_valid,
    output logic                           halted,
    output logic                           illegal,
    output logic [63:0]                    retire_count
);

    // Field offsets inside one commit entry
    localparam int PRN_LSB      = 0;
    localparam int ARN_LSB      = PRN_WIDTH;
    localparam int PC_LSB       = PRN_WIDTH + ARN_WIDTH;
    localparam int ILLEGAL_BIT  = PC_LSB + 32;
    localparam int HALT_BIT     = PC_LSB + 33;
    localparam int SUCCESS_BIT  = PC_LSB + 34;
    localparam int EXECUTED_BIT = PC_LSB + 35;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    // ------------------------------------------------------------------
    // Unpacked view of the commit packet
    // ------------------------------------------------------------------
    logic [N-1:0]           slot_executed;
    logic [N-1:0]           slot_success;
    logic [N-1:0]           slot_halt;
    logic [N-1:0]           slot_illegal;
    logic [31:0]            slot_pc  [N];
    logic [ARN_WIDTH-1:0]   slot_arn [N];
    logic [PRN_WIDTH-1:0]   slot_prn [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            localparam int BASE = gi * ENTRY_WIDTH;
            assign slot_executed[gi] = rob_ct_packet[BASE + EXECUTED_BIT];
            assign slot_success[gi]  = rob_ct_packet[BASE + SUCCESS_BIT];
            assign slot_halt[gi]     = rob_ct_packet[BASE + HALT_BIT];
            assign slot_illegal[gi]  = rob_ct_packet[BASE + ILLEGAL_BIT];
            assign slot_pc[gi]       = rob_ct_packet[BASE + PC_LSB +: 32];
            assign slot_arn[gi]      = rob_ct_packet[BASE + ARN_LSB +: ARN_WIDTH];
            assign slot_prn[gi]      = rob_ct_packet[BASE + PRN_LSB +: PRN_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic [PRN_WIDTH-1:0]   arch_map_reg [ARCH_REGS];
    logic [N-1:0]           retire_valid_reg;
    logic [31:0]            retire_pc_reg [N];
    logic [N-1:0]           free_valid_reg;
    logic [PRN_WIDTH-1:0]   free_prn_reg [N];
    logic                   recover_valid_reg;
    logic                   halted_reg;
    logic                   illegal_reg;
    logic [63:0]            retire_count_reg;

    // ------------------------------------------------------------------
    // Retirement decision and map update for this cycle
    // ------------------------------------------------------------------
    logic [N-1:0]           retire_mask_next;
    logic [31:0]            retire_pc_next [N];
    logic [N-1:0]           free_valid_next;
    logic [PRN_WIDTH-1:0]   free_prn_next [N];
    logic [PRN_WIDTH-1:0]   arch_map_next [ARCH_REGS];
    logic [63:0]            retire_add_next;
    logic                   stop_hit_next;
    logic                   illegal_hit_next;
    logic                   recover_valid_next;

    always_comb begin
        // "open" stays 1 while every older slot retired and none of them
        // ended the retire group (halt, illegal or mispredict).
        logic open;
        open               = (state_reg == ST_RUN);
        retire_mask_next   = '0;
        free_valid_next    = '0;
        retire_add_next    = '0;
        stop_hit_next      = 1'b0;
        illegal_hit_next   = 1'b0;
        arch_map_next      = arch_map_reg;
        for (int i = 0; i < N; i++) begin
            retire_pc_next[i] = '0;
            free_prn_next[i]  = '0;
        end

        for (int i = 0; i < N; i++) begin
            if (open && slot_executed[i]) begin
                retire_mask_next[i] = 1'b1;
                retire_pc_next[i]   = slot_pc[i];
                retire_add_next     = retire_add_next + 64'd1;
                // Reading arch_map_next (not arch_map_reg) chains same-arn
                // writes inside one cycle: a younger slot frees the PRN an
                // older slot installed a moment earlier.
                if (slot_arn[i] != '0) begin
                    free_valid_next[i]          = 1'b1;
                    free_prn_next[i]            = arch_map_next[slot_arn[i]];
                    arch_map_next[slot_arn[i]]  = slot_prn[i];
                end
                if (slot_halt[i] || slot_illegal[i]) begin
                    stop_hit_next = 1'b1;
                end
                if (slot_illegal[i]) begin
                    illegal_hit_next = 1'b1;
                end
                open = slot_success[i] && !slot_halt[i] && !slot_illegal[i];
            end else begin
                open = 1'b0;
            end
        end

        recover_valid_next = squash && (state_reg == ST_RUN);
    end

    // ------------------------------------------------------------------
    // Registered FSM and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= ST_RUN;
            retire_valid_reg  <= '0;
            free_valid_reg    <= '0;
            recover_valid_reg <= 1'b0;
            halted_reg        <= 1'b0;
            illegal_reg       <= 1'b0;
            retire_count_reg  <= '0;
            for (int i = 0; i < N; i++) begin
                retire_pc_reg[i] <= '0;
                free_prn_reg[i]  <= '0;
            end
            for (int r = 0; r < ARCH_REGS; r++) begin
                arch_map_reg[r] <= PRN_WIDTH'(r);
            end
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (stop_hit_next) begin
                        state_reg <= ST_HALTED;
                    end
                end
                default: begin
                    state_reg <= ST_HALTED;
                end
            endcase
            // In HALTED the retire mask is empty, so everything below
            // naturally freezes or clears.
            retire_valid_reg  <= retire_mask_next;
            free_valid_reg    <= free_valid_next;
            recover_valid_reg <= recover_valid_next;
            halted_reg        <= halted_reg | stop_hit_next;
            illegal_reg       <= illegal_reg | illegal_hit_next;
            retire_count_reg  <= retire_count_reg + retire_add_next;
            for (int i = 0; i < N; i++) begin
                retire_pc_reg[i] <= retire_pc_next[i];
                free_prn_reg[i]  <= free_prn_next[i];
            end
            arch_map_reg <= arch_map_next;
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot_out
            assign retire_pc[gi*32 +: 32]              = retire_pc_reg[gi];
            assign free_prn[gi*PRN_WIDTH +: PRN_WIDTH] = free_prn_reg[gi];
        end
        for (genvar gi = 0; gi < ARCH_REGS; gi++) begin : g_map_out
            assign arch_map[gi*PRN_WIDTH +: PRN_WIDTH] = arch_map_reg[gi];
        end
    endgenerate

    assign retire_valid  = retire_valid_reg;
    assign free_valid    = free_valid_reg;
    assign recover_valid = recover_valid_reg;
    assign halted        = halted_reg;
    assign illegal       = illegal_reg;
    assign retire_count  = retire_count_reg;

endmodule
